// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and default widths for the two-port next-level cache arbiter.
package cachepkg;

  localparam int ADDRBITS_DEF = 32;
  localparam int LINEBITS_DEF = 512;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } arb_state_t;

  // One completion bit per requester port, bit index = port number.
  typedef logic [1:0] valid_t;

endpackage

// File: rtl/cache_port_arbiter_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time. Grant is one-hot, all zero when nobody asks.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one next-level cache port between two requesters, one transaction at a time.
// Optional ISSUE watchdog enabled with CACHE_ARB_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a request while no evict notice is pending
// ISSUE   | latched transaction driven on nl_*, waiting for nl_valid
// RESPOND | one-cycle completion pulse and read data to the owner
module cache_port_arbiter
  import cachepkg::*;
#(
  parameter int ADDRBITS = ADDRBITS_DEF,
  parameter int LINEBITS = LINEBITS_DEF,
  parameter int TIMEOUT  = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                p0_request,
  input  op_t                 p0_operation,
  input  logic [ADDRBITS-1:0] p0_addr,
  input  logic [LINEBITS-1:0] p0_wdata,
  output logic [LINEBITS-1:0] p0_rdata,
  output logic                p0_valid,
  output logic                p0_evict,
  input  logic                p1_request,
  input  op_t                 p1_operation,
  input  logic [ADDRBITS-1:0] p1_addr,
  input  logic [LINEBITS-1:0] p1_wdata,
  output logic [LINEBITS-1:0] p1_rdata,
  output logic                p1_valid,
  output logic                p1_evict,
  output logic                nl_request,
  output op_t                 nl_operation,
  output logic [ADDRBITS-1:0] nl_addr,
  output logic [LINEBITS-1:0] nl_wdata,
  input  logic [LINEBITS-1:0] nl_rdata,
  input  logic                nl_valid,
  input  logic                nl_evict,
  output logic                busy,
  output logic                owner,
  output logic                timeout_err
);

  arb_state_t          state;
  logic                owner_r;
  logic                last_grant;
  valid_t              valid_r;
  logic [LINEBITS-1:0] rdata_r;

  logic [1:0]          gnt;
  logic                gnt_idx;
  op_t                 sel_op;
  logic [ADDRBITS-1:0] sel_addr;
  logic [LINEBITS-1:0] sel_wdata;

  arb_rr2 u_rr (
    .req   ({p1_request, p0_request}),
    .last  (last_grant),
    .grant (gnt)
  );

  assign gnt_idx   = gnt[1];
  assign sel_op    = gnt_idx ? p1_operation : p0_operation;
  assign sel_addr  = gnt_idx ? p1_addr      : p0_addr;
  assign sel_wdata = gnt_idx ? p1_wdata     : p0_wdata;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CNTBITS = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(TIMEOUT - 1);

  logic [CNTBITS-1:0] cnt;
  logic               timeout_err_r;
  logic               expire;

  // cnt counts completed ISSUE cycles, so the watchdog fires after TIMEOUT of them.
  assign expire      = (cnt == CNT_LAST);
  assign timeout_err = timeout_err_r;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner_r      <= 1'b0;
      last_grant   <= 1'b1;
      valid_r      <= '0;
      rdata_r      <= '0;
      nl_request   <= 1'b0;
      nl_operation <= NOP;
      nl_addr      <= '0;
      nl_wdata     <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt          <= '0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!nl_evict && (gnt != 2'b00)) begin
            owner_r <= gnt_idx;
            if (sel_op == NOP) begin
              rdata_r <= '0;
              valid_r <= valid_t'(gnt);
              state   <= RESPOND;
            end else begin
              nl_request   <= 1'b1;
              nl_operation <= sel_op;
              nl_addr      <= sel_addr;
              nl_wdata     <= (sel_op == READ) ? '0 : sel_wdata;
              state        <= ISSUE;
`ifdef CACHE_ARB_TIMEOUT_EN
              cnt          <= '0;
`endif
            end
          end
        end
        ISSUE: begin
          if (nl_valid) begin
            rdata_r      <= (nl_operation == READ) ? nl_rdata : '0;
            valid_r      <= owner_r ? 2'b10 : 2'b01;
            nl_request   <= 1'b0;
            nl_operation <= NOP;
            nl_addr      <= '0;
            nl_wdata     <= '0;
            state        <= RESPOND;
          end
`ifdef CACHE_ARB_TIMEOUT_EN
          else if (expire) begin
            nl_request    <= 1'b0;
            nl_operation  <= NOP;
            nl_addr       <= '0;
            nl_wdata      <= '0;
            timeout_err_r <= 1'b1;
            last_grant    <= owner_r;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESPOND: begin
          valid_r    <= '0;
          last_grant <= owner_r;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_valid = valid_r[0];
  assign p1_valid = valid_r[1];
  assign p0_rdata = valid_r[0] ? rdata_r : '0;
  assign p1_rdata = valid_r[1] ? rdata_r : '0;
  assign p0_evict = nl_evict;
  assign p1_evict = nl_evict;
  assign busy     = (state != IDLE);
  assign owner    = owner_r;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: vector table, scoreboard queue,
// behavioural next-level responder, and hand sequences for evict/reset/timeout.
module tb_cache_port_arbiter;
  import cachepkg::*;

  localparam int AW = 32;
  localparam int LW = 512;
`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          p0_request, p1_request;
  op_t           p0_operation, p1_operation;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [LW-1:0] p0_wdata, p1_wdata;
  logic [LW-1:0] p0_rdata, p1_rdata;
  logic          p0_valid, p1_valid, p0_evict, p1_evict;
  logic          nl_request;
  op_t           nl_operation;
  logic [AW-1:0] nl_addr;
  logic [LW-1:0] nl_wdata, nl_rdata;
  logic          nl_valid, nl_evict;
  logic          busy, owner, timeout_err;

  cache_port_arbiter #(.ADDRBITS(AW), .LINEBITS(LW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .p0_request(p0_request), .p0_operation(p0_operation), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_valid(p0_valid), .p0_evict(p0_evict),
    .p1_request(p1_request), .p1_operation(p1_operation), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_valid(p1_valid), .p1_evict(p1_evict),
    .nl_request(nl_request), .nl_operation(nl_operation), .nl_addr(nl_addr),
    .nl_wdata(nl_wdata), .nl_rdata(nl_rdata), .nl_valid(nl_valid), .nl_evict(nl_evict),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            port;
    op_t           op;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_t;

  typedef struct {
    logic [1:0]  req;
    op_t         op0;
    op_t         op1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] w0;
    logic [31:0] w1;
    int          first;
  } vec_t;

  txn_t exp_q[$];
  vec_t vec[8];
  int   total = 0;
  int   bad   = 0;
  bit   resp_en = 1'b1;

  function automatic logic [LW-1:0] resp(input logic [AW-1:0] a);
    return {16{a ^ 32'h0000_1000}} ^ {64{8'hA5}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input op_t op, input logic [31:0] a, input logic [31:0] ws);
    if (p == 0) begin
      p0_operation = op; p0_addr = a; p0_wdata = {16{ws}}; p0_request = 1'b1;
    end else begin
      p1_operation = op; p1_addr = a; p1_wdata = {16{ws}}; p1_request = 1'b1;
    end
  endtask

  task automatic push(input int p);
    txn_t t;
    t.port  = p;
    t.op    = (p == 1) ? p1_operation : p0_operation;
    t.addr  = (p == 1) ? p1_addr : p0_addr;
    t.wdata = (p == 1) ? p1_wdata : p0_wdata;
    t.rdata = (t.op == READ) ? resp(t.addr) : '0;
    exp_q.push_back(t);
  endtask

  // One cycle: sample at the falling edge, check completions, act as next level.
  task automatic tick();
    txn_t e;
    @(negedge clock);
    chk("p0_evict", 512'(p0_evict), 512'(nl_evict));
    chk("p1_evict", 512'(p1_evict), 512'(nl_evict));
    if (p0_valid || p1_valid) begin
      chk("single_valid", 512'(p0_valid & p1_valid), 512'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 512'({p1_valid, p0_valid}), 512'd0);
      end else begin
        e = exp_q.pop_front();
        chk("valid_port", p1_valid ? 512'd1 : 512'd0, 512'(e.port));
        chk("owner_rdata", p1_valid ? p1_rdata : p0_rdata, e.rdata);
        chk("other_rdata", p1_valid ? p0_rdata : p1_rdata, '0);
      end
      if (p0_valid) p0_request = 1'b0;
      if (p1_valid) p1_request = 1'b0;
    end
    nl_valid = 1'b0;
    if (nl_request && resp_en && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("nl_operation", 512'(nl_operation), 512'(e.op));
      chk("nl_addr", 512'(nl_addr), 512'(e.addr));
      chk("nl_wdata", nl_wdata, (e.op == READ) ? '0 : e.wdata);
      nl_rdata = resp(e.addr);
      nl_valid = 1'b1;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      chk("completion_timeout", 512'(exp_q.size()), 512'd0);
      exp_q.delete();
      p0_request = 1'b0;
      p1_request = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hi;
    vec[0] = '{2'b10, NOP,   WRITE, 32'h0,      32'h2000,   32'h0,        32'hDEAD0001, 1};
    vec[1] = '{2'b11, READ,  READ,  32'h1100,   32'h2100,   32'h0,        32'h0,        0};
    vec[2] = '{2'b11, WRITE, READ,  32'h1200,   32'h2200,   32'h12345678, 32'h0,        0};
    vec[3] = '{2'b11, READ,  WRITE, 32'h1300,   32'h2300,   32'h0,        32'hCAFEF00D, 0};
    vec[4] = '{2'b11, WRITE, WRITE, 32'h1400,   32'h2400,   32'h0BADBEEF, 32'h600DF00D, 0};
    vec[5] = '{2'b01, NOP,   NOP,   32'h1500,   32'h0,      32'h0,        32'h0,        0};
    vec[6] = '{2'b11, WRITE, NOP,   32'h1600,   32'h2600,   32'hA1B2C3D4, 32'h0,        1};
    vec[7] = '{2'b11, READ,  READ,  32'h1700,   32'h2700,   32'h0,        32'h0,        1};

    reset = 1'b1;
    p0_request = 1'b0; p1_request = 1'b0;
    p0_operation = NOP; p1_operation = NOP;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    nl_rdata = '0; nl_valid = 1'b0; nl_evict = 1'b0;

    tick(); tick();
    chk("rst_nl_request", 512'(nl_request), 512'd0);
    chk("rst_nl_operation", 512'(nl_operation), 512'(NOP));
    chk("rst_nl_addr", 512'(nl_addr), 512'd0);
    chk("rst_nl_wdata", nl_wdata, '0);
    chk("rst_p0_valid", 512'(p0_valid), 512'd0);
    chk("rst_p1_valid", 512'(p1_valid), 512'd0);
    chk("rst_p0_rdata", p0_rdata, '0);
    chk("rst_p1_rdata", p1_rdata, '0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_owner", 512'(owner), 512'd0);
    chk("rst_timeout_err", 512'(timeout_err), 512'd0);
    reset = 1'b0;
    tick();

    // p0 READ with an immediate next-level answer: valid two cycles after sampling.
    drive(0, READ, 32'h0000_1000, 32'h0);
    push(0);
    tick();
    chk("lat_busy", 512'(busy), 512'd1);
    chk("lat_nl_request", 512'(nl_request), 512'd1);
    tick();
    chk("lat_p0_valid", 512'(p0_valid), 512'd1);
    chk("lat_p1_valid", 512'(p1_valid), 512'd0);
    tick();
    chk("lat_pulse_done", 512'(p0_valid), 512'd0);
    chk("lat_idle", 512'(busy), 512'd0);

    foreach (vec[i]) begin
      if (vec[i].req[0]) drive(0, vec[i].op0, vec[i].a0, vec[i].w0);
      if (vec[i].req[1]) drive(1, vec[i].op1, vec[i].a1, vec[i].w1);
      if (vec[i].req == 2'b11) begin
        push(vec[i].first);
        push(1 - vec[i].first);
      end else begin
        push(vec[i].req[1] ? 1 : 0);
      end
      wait_done();
      tick();
    end

    // Evict notice blocks arbitration; grant follows the cycle it drops.
    nl_evict = 1'b1;
    drive(1, WRITE, 32'h3000, 32'h5A5A0003);
    push(1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("evict_no_grant", 512'(busy), 512'd0);
      chk("evict_no_nl_req", 512'(nl_request), 512'd0);
    end
    nl_evict = 1'b0;
    tick();
    chk("evict_grant", 512'(busy), 512'd1);
    chk("evict_owner", 512'(owner), 512'd1);
    wait_done();
    tick();

    // Leave last_grant at 0, then abort a transaction by reset.
    drive(0, READ, 32'h1800, 32'h0);
    push(0);
    wait_done();
    tick();
    resp_en = 1'b0;
    drive(0, READ, 32'h1900, 32'h0);
    tick();
    chk("abort_issue", 512'(nl_request), 512'd1);
    reset = 1'b1;
    #1;
    chk("abort_nl_request", 512'(nl_request), 512'd0);
    chk("abort_busy", 512'(busy), 512'd0);
    p0_request = 1'b0;
    tick();
    chk("abort_no_valid", 512'({p1_valid, p0_valid}), 512'd0);
    tick();
    reset = 1'b0;
    resp_en = 1'b1;
    tick();
    drive(0, READ, 32'h1A00, 32'h0);
    drive(1, WRITE, 32'h2A00, 32'h77778888);
    push(0);
    push(1);
    wait_done();
    tick();

`ifdef CACHE_ARB_TIMEOUT_EN
    resp_en = 1'b0;
    n_hi = 0;
    drive(0, READ, 32'h4000, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) drive(1, READ, 32'h5000, 32'h0);
      if (nl_request) n_hi++;
      else if (n_hi > 0) break;
    end
    chk("to_request_cycles", 512'(n_hi), 512'd4);
    chk("to_err_set", 512'(timeout_err), 512'd1);
    chk("to_no_p0_valid", 512'(p0_valid), 512'd0);
    p0_request = 1'b0;
    push(1);
    resp_en = 1'b1;
    wait_done();
    tick();
    chk("to_err_sticky", 512'(timeout_err), 512'd1);
`else
    n_hi = 0;
    chk("no_timeout_err", 512'(timeout_err), 512'(n_hi));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
